disp_scan_ctrl: RTL and testbench
=================================

DISP_SCAN_CTRL -- requirements
Module: disp_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 10000: digit dwell time in CLK cycles; legal values are 2 or more.
REQ-002 SHALL have parameter GUARD, default 16: anti-ghost blank cycles at the start of each dwell; GUARD < CLK_DIV.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port DI, input, 32 bits: eight hex nibbles; nibble i drives digit i, digit 0 rightmost.
REQ-006 SHALL have port DP, input, 8 bits: decimal point request per digit.
REQ-007 SHALL have port EN, input, 8 bits: digit enable mask; a 0 blanks that digit.
REQ-008 SHALL have port LZB, input, 1 bit: leading-zero blanking enable.
REQ-009 SHALL have port HOLD, input, 1 bit: freezes the shadow data register while high.
REQ-010 SHALL have port seg, output, 8 bits: active-low segments; seg[6:0]=g..a, seg[7]=dp.
REQ-011 SHALL have port an, output, 8 bits: active-low anodes; an[i] selects digit i.
REQ-012 SHALL have port FRAME, output, 1 bit: one-cycle pulse at each frame boundary.

Function
REQ-013 SHALL use a prescaler counting 0..CLK_DIV-1, wrapping to 0; tick is asserted when the prescaler equals CLK_DIV-1.
REQ-014 SHALL advance the digit index 0..7 on each tick, wrapping 7 -> 0.
REQ-015 SHALL raise the frame event on a tick with index==7; the FRAME register is 1 for exactly the following cycle.
REQ-016 SHALL load the shadow register from DI on the frame event when HOLD==0; it SHALL be unchanged otherwise, so DI changes mid-frame never tear the display.
REQ-017 SHALL treat digit i as visible iff EN[i]==1 and not lz-blanked.
REQ-018 SHALL define lz-blanked (LZB==1 only) as: i != 0 and shadow nibbles i..7 all zero; digit 0 is never lz-blanked.
REQ-019 SHALL drive an[i] low iff i==index, digit i is visible, and prescaler >= GUARD; otherwise an[i] is high.
REQ-020 SHALL drive seg[6:0] from the hex decode of shadow nibble[index], and seg[7] = ~DP[index].
REQ-021 SHALL use the hex decode (g..a, active low): 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110, with the standard pattern for all other nibbles.
REQ-022 SHALL register seg, an and FRAME, giving a latency of one CLK from the index/prescaler state to the pins.
REQ-023 SHALL drive seg=8'hFF whenever all anodes are off.
REQ-024 SHALL give HOLD going low precedence only at the next frame event; there is no immediate reload.
REQ-025 SHALL sample EN, DP and LZB live each cycle; they are not shadowed.

Reset
REQ-026 SHALL, while RESET is high, force prescaler=0, index=0, shadow=0, an=8'hFF, seg=8'hFF, FRAME=0, independent of CLK.
REQ-027 SHALL, after RESET falls, start at prescaler=0, index=0; the first tick occurs CLK_DIV cycles later.
REQ-028 SHALL, when RESET is asserted mid-frame, abandon the frame with no FRAME pulse and clear shadow.

Structure
REQ-029 SHALL place the 16-entry hex-to-segment constant table, the active-low all-off constants and the digit count (8) in shared package disp_pkg.
REQ-030 SHALL implement the decode as a combinational sub-module hex7_dec (nibble in, seg[6:0] out), shareable with other display blocks.
REQ-031 SHALL keep all state (prescaler, index, shadow, output registers) in disp_scan_ctrl; no second clock domain.

Verification (CLK_DIV=4, GUARD=1)
REQ-032 SHALL cover: reset, DI=32'h12345678, EN=FF, HOLD=0, run 40 cycles -> after the first frame event the anode sequence is FE,FD,..,7F, each low 3 cycles after 1 blank cycle, and the digit-0 pattern is "8"=seg FF->80 (dp off).
REQ-033 SHALL cover: DI=32'h0000_00A0, LZB=1 -> only digits 0 and 1 light; digit 1 shows A (0001000), digit 0 shows 0 (1000000); an stays FF in the digit 2..7 slots.
REQ-034 SHALL cover: HOLD=1, DI changed 32'h1 -> 32'hFFFFFFFF mid-frame -> display keeps old data for 3 frames; HOLD=0 -> all digits show F from the next frame, never a mixed frame.
REQ-035 SHALL cover: FRAME checking -> exactly one pulse per 32 cycles, coincident with index wrapping to 0; DP=8'h01 gives seg[7]=0 only in the digit-0 slot.
REQ-036 SHALL cover: RESET asserted asynchronously mid-dwell -> an=FF and seg=FF immediately without a clock edge; after release, the first anode low occurs at cycle CLK_DIV+GUARD+1 on digit 1.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for seven-segment display blocks.
//   NUM_DIGITS   - digits per scanned display
//   AN_ALL_OFF   - active-low anode vector with every digit dark
//   SEG_ALL_OFF  - active-low segment vector with every segment dark
//   HEX7_LUT     - hex nibble to active-low {g,f,e,d,c,b,a} patterns
package disp_pkg;

   localparam int unsigned NUM_DIGITS = 8;

   localparam logic [7:0] AN_ALL_OFF  = 8'hFF;
   localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

   typedef logic [2:0] digit_idx_t;
   typedef logic [3:0] nibble_t;

   // Entry 15 first, entry 0 last.
   localparam logic [15:0][6:0] HEX7_LUT = {
      7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
      7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
      7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
      7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
   };

endpackage

// File: rtl/hex7_dec.sv
// hex7_dec: combinational hex-to-seven-segment decoder.
//   nibble - 4-bit hex value
//   seg    - active-low segments, seg[6:0] = g..a
module hex7_dec
   import disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = HEX7_LUT[nibble];
   end

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: eight-digit multiplexed seven-segment scan controller.
//   CLK    - clock, rising edge
//   RESET  - asynchronous active-high reset
//   DI     - eight hex nibbles, nibble i shown on digit i (digit 0 rightmost)
//   DP     - decimal point request per digit (live)
//   EN     - digit enable mask, 0 blanks the digit (live)
//   LZB    - leading-zero blanking enable (live)
//   HOLD   - freezes the shadow data register while high
//   seg    - registered active-low segments, seg[7] = dp
//   an     - registered active-low anodes
//   FRAME  - registered one-cycle pulse at each frame boundary
// DI is captured into a shadow register only at frame boundaries so a frame
// never mixes old and new data.
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int unsigned CLK_DIV = 10000,
   parameter int unsigned GUARD   = 16
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] DI,
   input  logic [7:0]  DP,
   input  logic [7:0]  EN,
   input  logic        LZB,
   input  logic        HOLD,
   output logic [7:0]  seg,
   output logic [7:0]  an,
   output logic        FRAME
);

   localparam int unsigned   PW         = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] GUARD_CNT  = PW'(GUARD);

   logic [PW-1:0]                 presc_q, presc_d;
   digit_idx_t                    idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0]    shadow_q, shadow_d;
   logic [7:0]                    an_q, an_d;
   logic [7:0]                    seg_q, seg_d;
   logic                          frame_q, frame_d;

   logic                          tick;
   logic                          frame_evt;
   logic [NUM_DIGITS-1:0]         lz_blank;
   logic [NUM_DIGITS-1:0]         visible;
   logic [6:0]                    dec_seg;

   hex7_dec u_hex7_dec (
      .nibble (shadow_q[idx_q]),
      .seg    (dec_seg)
   );

   // Walk from the top digit down; a digit is leading-zero blanked while it
   // and every digit above it hold zero. Digit 0 always stays eligible.
   always_comb begin
      logic upper_zero;
      upper_zero = 1'b1;
      lz_blank   = '0;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         upper_zero = upper_zero & (shadow_q[NUM_DIGITS-1-k] == 4'h0);
         lz_blank[NUM_DIGITS-1-k] = LZB & upper_zero & (k != NUM_DIGITS-1);
      end
      visible = EN & ~lz_blank;
   end

   always_comb begin
      tick      = (presc_q == PRESC_LAST);
      frame_evt = tick && (idx_q == digit_idx_t'(NUM_DIGITS - 1));

      presc_d  = tick ? '0 : presc_q + 1'b1;
      idx_d    = tick ? idx_q + 1'b1 : idx_q;
      shadow_d = (frame_evt && !HOLD) ? DI : shadow_q;

      // Anode held off for the first GUARD cycles of each dwell to hide
      // ghosting while the segment lines settle to the new digit.
      an_d = AN_ALL_OFF;
      if (visible[idx_q] && (presc_q >= GUARD_CNT)) begin
         an_d[idx_q] = 1'b0;
      end

      seg_d   = (an_d == AN_ALL_OFF) ? SEG_ALL_OFF : {~DP[idx_q], dec_seg};
      frame_d = frame_evt;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         presc_q  <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         an_q     <= AN_ALL_OFF;
         seg_q    <= SEG_ALL_OFF;
         frame_q  <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         shadow_q <= shadow_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
         frame_q  <= frame_d;
      end
   end

   assign seg   = seg_q;
   assign an    = an_q;
   assign FRAME = frame_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed self-checking bench for disp_scan_ctrl
// with CLK_DIV=4, GUARD=1 (one frame = 32 cycles).
module tb_disp_scan_ctrl;

   logic        CLK;
   logic        RESET;
   logic [31:0] DI;
   logic [7:0]  DP;
   logic [7:0]  EN;
   logic        LZB;
   logic        HOLD;
   logic [7:0]  seg;
   logic [7:0]  an;
   logic        FRAME;

   int checks = 0;
   int errors = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   disp_scan_ctrl #(
      .CLK_DIV (4),
      .GUARD   (1)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .DI    (DI),
      .DP    (DP),
      .EN    (EN),
      .LZB   (LZB),
      .HOLD  (HOLD),
      .seg   (seg),
      .an    (an),
      .FRAME (FRAME)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Checks one full frame, starting from a sample where FRAME is high.
   // exp_seg holds the expected lit pattern per digit (digit 7 in the top
   // byte); 8'hFF marks a digit that must stay dark. Optionally changes
   // DI/HOLD halfway through the frame.
   task automatic scan_frame(input string tag, input logic [63:0] exp_seg,
                             input logic mid_en, input logic [31:0] mid_di,
                             input logic mid_hold);
      logic [7:0] es;
      logic [7:0] ea;
      for (int d = 0; d < 8; d++) begin
         for (int p = 0; p < 4; p++) begin
            @(negedge CLK);
            es = exp_seg[8*d +: 8];
            if (p == 0 || es == 8'hFF) begin
               es = 8'hFF;
               ea = 8'hFF;
            end else begin
               ea = ~(8'h01 << d);
            end
            chk($sformatf("%s an d%0d p%0d", tag, d, p), {24'h0, an}, {24'h0, ea});
            chk($sformatf("%s seg d%0d p%0d", tag, d, p), {24'h0, seg}, {24'h0, es});
            chk($sformatf("%s frame d%0d p%0d", tag, d, p), {31'h0, FRAME},
                {31'h0, (d == 7 && p == 3)});
            if (mid_en && d == 3 && p == 3) begin
               DI   = mid_di;
               HOLD = mid_hold;
            end
         end
      end
   endtask

   initial begin
      logic fseen;

      RESET = 1'b1;
      DI    = 32'h1234_5678;
      DP    = 8'h00;
      EN    = 8'hFF;
      LZB   = 1'b0;
      HOLD  = 1'b0;

      repeat (3) @(negedge CLK);
      chk("reset an", {24'h0, an}, 32'hFF);
      chk("reset seg", {24'h0, seg}, 32'hFF);
      chk("reset frame", {31'h0, FRAME}, 32'h0);

      RESET = 1'b0;
      @(negedge CLK);
      chk("k1 guard an", {24'h0, an}, 32'hFF);
      chk("k1 guard seg", {24'h0, seg}, 32'hFF);
      @(negedge CLK);
      chk("k2 an", {24'h0, an}, 32'hFE);
      chk("k2 seg zero shadow", {24'h0, seg}, 32'hC0);
      fseen = 1'b0;
      repeat (29) begin
         @(negedge CLK);
         fseen |= FRAME;
      end
      chk("no early frame", {31'h0, fseen}, 32'h0);
      @(negedge CLK);
      chk("first frame k32", {31'h0, FRAME}, 32'h1);

      scan_frame("f12345678", 64'hF9A4B099_9282F880, 1'b0, 32'h0, 1'b0);

      // New DI and LZB: display keeps old shadow for this frame.
      DI  = 32'h0000_00A0;
      LZB = 1'b1;
      scan_frame("noreload", 64'hF9A4B099_9282F880, 1'b0, 32'h0, 1'b0);
      scan_frame("lzb", 64'hFFFFFFFF_FFFF88C0, 1'b0, 32'h0, 1'b0);

      DP = 8'h01;
      scan_frame("dp0", 64'hFFFFFFFF_FFFF8840, 1'b0, 32'h0, 1'b0);

      DP  = 8'h00;
      LZB = 1'b0;
      DI  = 32'h0000_0001;
      scan_frame("nolzb", 64'hC0C0C0C0_C0C088C0, 1'b0, 32'h0, 1'b0);

      HOLD = 1'b1;
      scan_frame("hold1", 64'hC0C0C0C0_C0C0C0F9, 1'b1, 32'hFFFF_FFFF, 1'b1);
      scan_frame("hold2", 64'hC0C0C0C0_C0C0C0F9, 1'b0, 32'h0, 1'b0);
      scan_frame("hold3", 64'hC0C0C0C0_C0C0C0F9, 1'b1, 32'hFFFF_FFFF, 1'b0);
      scan_frame("allF", 64'h8E8E8E8E_8E8E8E8E, 1'b0, 32'h0, 1'b0);

      // Asynchronous reset in the middle of a lit dwell.
      @(negedge CLK);
      @(negedge CLK);
      chk("pre-reset an", {24'h0, an}, 32'hFE);
      chk("pre-reset seg", {24'h0, seg}, 32'h8E);
      #2 RESET = 1'b1;
      #1;
      chk("async reset an", {24'h0, an}, 32'hFF);
      chk("async reset seg", {24'h0, seg}, 32'hFF);
      chk("async reset frame", {31'h0, FRAME}, 32'h0);
      EN = 8'hFE;
      @(negedge CLK);
      @(negedge CLK);
      RESET = 1'b0;

      fseen = 1'b0;
      for (int k = 1; k <= 31; k++) begin
         @(negedge CLK);
         fseen |= FRAME;
         if (k <= 5) chk($sformatf("post-reset dark k%0d", k), {24'h0, an}, 32'hFF);
         if (k == 6) begin
            chk("post-reset first anode", {24'h0, an}, 32'hFD);
            chk("post-reset shadow cleared", {24'h0, seg}, 32'hC0);
         end
      end
      chk("post-reset no frame", {31'h0, fseen}, 32'h0);
      @(negedge CLK);
      chk("post-reset frame k32", {31'h0, FRAME}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
